term_tx_buf: RTL and testbench
==============================

Name: term_tx_buf

Overview:
- Output-side companion to the keyboard input buffer. The CPU writes 7-bit ASCII characters into a 32-entry FIFO. A UART transmitter drains the FIFO and sends each character as an 8N1 frame on the serial line to the host terminal.
- Sits between the CPU output-port logic and the board UART TX pin. Status outputs let software poll for space before writing.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- Derived: CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer division (868 at defaults); must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  CPU write strobe for one character; one write per cycle maximum.
- wr_data  in  7  ASCII character to enqueue.
- clear  in  1  synchronous FIFO flush; the frame already in flight is unaffected.
- tx  out  1  serial output; idles at 1.
- buf_full  out  1  FIFO holds 32 entries.
- buf_empty  out  1  FIFO holds 0 entries.
- count  out  6  FIFO occupancy, 0..32.
- tx_busy  out  1  high while a frame is being sent (FSM state != IDLE).

Behaviour:
- Reset (async): tx=1, FSM=IDLE, both pointers=0, count=0, buf_empty=1, buf_full=0, tx_busy=0. A reset mid-frame drives tx to 1 immediately; the truncated frame is acceptable.
- FIFO pointers are 6 bits: 5 address bits plus a wrap bit. count = wr_ptr - rd_ptr, computed mod 64.
  - buf_empty when the pointers are equal.
  - buf_full when the address bits are equal and the wrap bits differ.
  - All status outputs are combinational from the registered pointers.
- Storage is 32x7. The read port is asynchronous, addressed by rd_ptr[4:0].
- Write rule:
  - A write is accepted when wr_en=1 and buf_full=0, judged on the pre-edge value. The entry is stored and wr_ptr increments.
  - A write while full is dropped silently and the pointers are unchanged.
  - A write and a pop in the same cycle while full: the write is still rejected.
  - A write while empty is accepted; it is popped no earlier than the next edge.
- Clear: when clear=1, both pointers go to 0 at the edge. Clear wins over a simultaneous write and a simultaneous pop. The shift register and FSM continue the current frame.
- Transmitter FSM, states IDLE, START, DATA, STOP; bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
  - IDLE: tx=1. If buf_empty=0 at an edge: pop (rd_ptr+1), load shift={1'b0, head[6:0]}, set baud counter to 0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After 8 bits (LSB first; bit7 always 0), go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - tx is registered and reflects the state entered at each edge.
- Latency:
  - A write accepted at edge E into an empty FIFO while IDLE: the pop happens and tx falls at edge E+1.
  - The frame occupies 10*CLKS_PER_BIT cycles.
  - IDLE always lasts at least one cycle between frames, so back-to-back start bits are 10*CLKS_PER_BIT+1 cycles apart.
- The FIFO is never popped outside IDLE. At most one pop occurs per frame.

Test Plan:
- Use CLK_FREQ=40 and BAUD_RATE=10 (4 clocks/bit) for all scenarios.
- Single char: reset, then write 0x41 at edge 0.
  - Required: buf_empty=1 and tx=0 from edge 1 through edge 4.
  - Data bits sent are 1,0,0,0,0,0,1,0, each held 4 cycles.
  - Stop bit is high on edges 37-40; tx_busy falls at edge 41.
- Back-to-back: write 0x48 then 0x69 on consecutive cycles.
  - Required: second start bit falls exactly 41 cycles after the first.
  - Decoded serial stream is "Hi"; count goes 1,1,0 around the pops.
- Overflow: 34 consecutive writes of 0x30+i starting at edge 0.
  - Required: char 0 is popped at edge 1.
  - buf_full=1 and count=32 after the 33rd write; the 34th (0x51) is dropped.
  - 33 frames are sent with no 0x51.
- Full with simultaneous pop: hold the FIFO full with the FSM entering IDLE, and assert wr_en on the pop cycle.
  - Required: the write is rejected and count goes to 31.
- Clear mid-frame: queue 'a','b','c'; pulse clear during the DATA state of 'a'.
  - Required: 'a' completes intact.
  - buf_empty=1 and count=0 the edge after clear; tx stays 1 afterwards.
  - A write together with clear is also discarded.
- Async reset mid-frame: assert reset between edges while tx=0.
  - Required: tx=1 and tx_busy=0 without a clock edge, count=0.
  - After release, a new write produces a clean frame.

Source files
------------

// File: rtl/term_tx_buf_if.sv
// CPU-side port of the terminal transmit buffer: character writes, flush and
// occupancy status that software polls before writing.
interface term_tx_buf_if;
    logic       wr_en;
    logic [6:0] wr_data;
    logic       clear;
    logic       buf_full;
    logic       buf_empty;
    logic [5:0] count;

    modport master (
        output wr_en, wr_data, clear,
        input  buf_full, buf_empty, count
    );

    modport slave (
        input  wr_en, wr_data, clear,
        output buf_full, buf_empty, count
    );
endinterface

// File: rtl/term_tx_buf.sv
// Terminal output buffer: a 32-entry ASCII FIFO drained by an 8N1 UART
// transmitter that drives the board TX pin.
module term_tx_buf #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic          clk,
    input  logic          reset,
    term_tx_buf_if.slave  bus,
    output logic          tx,
    output logic          tx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [6:0]    mem_q [32];
    logic [5:0]    wr_ptr_q, wr_ptr_d;
    logic [5:0]    rd_ptr_q, rd_ptr_d;
    state_e        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic       empty, full, wr_accept, pop;
    logic [6:0] head;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[4:0] == rd_ptr_q[4:0]) && (wr_ptr_q[5] != rd_ptr_q[5]);
    assign head  = mem_q[rd_ptr_q[4:0]];

    // A flush cancels both a same-cycle write and a same-cycle frame start.
    assign wr_accept = bus.wr_en && !full && !bus.clear;
    assign pop       = (state_q == IDLE) && !empty && !bus.clear;

    assign bus.buf_empty = empty;
    assign bus.buf_full  = full;
    assign bus.count     = wr_ptr_q - rd_ptr_q;
    assign tx            = tx_q;
    assign tx_busy       = (state_q != IDLE);

    // NOTE: every signal gets its default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + 6'd1;
            if (pop)       rd_ptr_d = rd_ptr_q + 6'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = {1'b0, head};
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered and follows the state being entered.
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q[4:0]] <= bus.wr_data;
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            bit_q    <= '0;
            baud_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: tb/tb_term_tx_buf.sv
// Bench for term_tx_buf at 4 clocks/bit: queue-based reference model, UART
// decoder scoreboard, directed timing scenarios and a random traffic phase.
module tb_term_tx_buf;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic reset;
    logic tx;
    logic tx_busy;

    term_tx_buf_if bus ();

    term_tx_buf #(.CLK_FREQ(40), .BAUD_RATE(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a plain queue plus the number of busy cycles left in
    // the current frame; a new frame starts only from an idle line.
    logic [6:0] m_q[$];
    logic [6:0] exp_frames[$];
    logic [6:0] m_cur = '0;
    int         m_busy = 0;
    bit         pre_full, pre_empty, pre_idle;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            exp_frames.delete();
            m_busy = 0;
        end else begin
            pre_full  = (m_q.size() == 32);
            pre_empty = (m_q.size() == 0);
            pre_idle  = (m_busy == 0);
            if (m_busy > 0) m_busy--;
            if (bus.clear) begin
                m_q.delete();
            end else begin
                if (pre_idle && !pre_empty) begin
                    m_cur  = m_q.pop_front();
                    m_busy = FRAME;
                    exp_frames.push_back(m_cur);
                end
                if (bus.wr_en && !pre_full) m_q.push_back(bus.wr_data);
            end
        end
    end

    // Cycle-by-cycle comparison of line level and status against the model.
    logic m_tx;
    int   slot;
    always @(negedge clk) begin
        m_tx = 1'b1;
        if (m_busy != 0) begin
            slot = (FRAME - m_busy) / CPB;
            if (slot == 0)      m_tx = 1'b0;
            else if (slot <= 7) m_tx = m_cur[slot-1];
            else if (slot == 8) m_tx = 1'b0;
        end
        check("tx_line", tx, m_tx);
        check("tx_busy", tx_busy, m_busy != 0);
        check("count", bus.count, m_q.size());
        check("buf_empty", bus.buf_empty, m_q.size() == 0);
        check("buf_full", bus.buf_full, m_q.size() == 32);
    end

    // UART decoder: samples mid-bit and pops the expected frame on completion.
    bit         d_active = 0;
    int         d_cnt = 0;
    logic [7:0] d_bits = '0;
    logic [6:0] rx_log[$];
    int         rx_starts[$];
    logic [6:0] d_exp;

    always @(negedge clk) begin
        if (reset) begin
            d_active = 0;
        end else begin
            if (!d_active && tx === 1'b0) begin
                d_active = 1;
                d_cnt    = 0;
                rx_starts.push_back(cyc);
            end
            if (d_active) begin
                if (d_cnt % CPB == CPB / 2) begin
                    if (d_cnt / CPB >= 1 && d_cnt / CPB <= 8) d_bits[d_cnt/CPB-1] = tx;
                    if (d_cnt / CPB == 9) begin
                        check("rx_stop_bit", tx, 1'b1);
                        check("rx_bit7_zero", d_bits[7], 1'b0);
                        check("rx_frame_expected", exp_frames.size() != 0, 1'b1);
                        if (exp_frames.size() != 0) begin
                            d_exp = exp_frames.pop_front();
                            check("rx_char", d_bits[6:0], d_exp);
                        end
                        rx_log.push_back(d_bits[6:0]);
                    end
                end
                if (d_cnt == FRAME - 1) d_active = 0;
                else                    d_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((m_busy != 0 || m_q.size() != 0 || d_active) && n < limit) begin
            tick();
            n++;
        end
        check("drain_in_time", n < limit, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        logic       exp_bit;
        int         c0, n_rx;

        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.clear   = 1'b0;
        reset       = 1'b0;
        #1 reset    = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_count", bus.count, 6'd0);
        check("rst_empty", bus.buf_empty, 1'b1);
        check("rst_full", bus.buf_full, 1'b0);
        reset = 1'b0;
        tick();

        // Single character 'A': start on edges 1-4, data 5-36, stop 37-40.
        ch = 8'h41;
        bus.wr_en = 1'b1; bus.wr_data = ch[6:0];
        tick();
        bus.wr_en = 1'b0;
        c0 = cyc;
        check("single_count_e0", bus.count, 6'd1);
        for (int e = 1; e <= 41; e++) begin
            tick();
            if (e <= 4)       exp_bit = 1'b0;
            else if (e <= 36) exp_bit = ch[(e-5)/CPB];
            else              exp_bit = 1'b1;
            check("single_tx", tx, exp_bit);
            if (e <= 4)  check("single_empty", bus.buf_empty, 1'b1);
            if (e == 40) check("single_busy_e40", tx_busy, 1'b1);
            if (e == 41) check("single_busy_e41", tx_busy, 1'b0);
        end
        wait_idle(200);
        check("single_start_edge", rx_starts[$], c0 + 1);
        check("single_rx", rx_log[$], 7'h41);

        // Back-to-back "Hi".
        bus.wr_en = 1'b1; bus.wr_data = 7'h48;
        tick();
        check("b2b_count_e0", bus.count, 6'd1);
        bus.wr_data = 7'h69;
        tick();
        bus.wr_en = 1'b0;
        check("b2b_count_e1", bus.count, 6'd1);
        repeat (41) tick();
        check("b2b_count_e42", bus.count, 6'd0);
        wait_idle(200);
        check("b2b_gap", rx_starts[$] - rx_starts[$-1], 41);
        check("b2b_rx_H", rx_log[$-1], 7'h48);
        check("b2b_rx_i", rx_log[$], 7'h69);

        // Overflow with 34 writes, then a write on the pop edge while full.
        n_rx = rx_log.size();
        for (int i = 0; i < 34; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 7'(8'h30 + i);
            tick();
            if (i == 0) c0 = cyc;
            if (i == 32) begin
                check("ovf_full_e32", bus.buf_full, 1'b1);
                check("ovf_count_e32", bus.count, 6'd32);
            end
            if (i == 33) check("ovf_count_e33", bus.count, 6'd32);
        end
        bus.wr_en = 1'b0;
        repeat (8) tick();
        check("fullpop_count_e41", bus.count, 6'd32);
        bus.wr_en = 1'b1; bus.wr_data = 7'h7a;
        tick();
        bus.wr_en = 1'b0;
        check("fullpop_count_e42", bus.count, 6'd31);
        check("fullpop_full_e42", bus.buf_full, 1'b0);
        wait_idle(34 * 41 + 100);
        check("ovf_frames", rx_log.size() - n_rx, 33);
        check("ovf_first_start", rx_starts[n_rx], c0 + 1);
        for (int i = 0; i < 33; i++)
            check("ovf_rx_char", rx_log[n_rx+i], 7'(8'h30 + i));

        // Clear during the data bits of 'a'; 'x' written with the clear is lost.
        n_rx = rx_log.size();
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 7'(8'h61 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        repeat (7) tick();
        bus.clear = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 7'h78;
        tick();
        bus.clear = 1'b0; bus.wr_en = 1'b0;
        check("clr_empty", bus.buf_empty, 1'b1);
        check("clr_count", bus.count, 6'd0);
        check("clr_busy", tx_busy, 1'b1);
        wait_idle(200);
        check("clr_frames", rx_log.size() - n_rx, 1);
        check("clr_rx_a", rx_log[$], 7'h61);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("clr_tx_idle", tx, 1'b1);
        end

        // Asynchronous reset while the start bit is on the line.
        n_rx = rx_log.size();
        bus.wr_en = 1'b1; bus.wr_data = 7'h72;
        tick();
        bus.wr_en = 1'b0; bus.wr_data = 7'h6b;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        tick();
        check("arst_tx_low", tx, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_tx", tx, 1'b1);
        check("arst_busy", tx_busy, 1'b0);
        check("arst_count", bus.count, 6'd0);
        tick();
        reset = 1'b0;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 7'h4b;
        tick();
        bus.wr_en = 1'b0;
        wait_idle(200);
        check("arst_frames", rx_log.size() - n_rx, 1);
        check("arst_rx_K", rx_log[$], 7'h4b);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 25);
            bus.wr_data = 7'($urandom);
            bus.clear   = ($urandom_range(0, 249) == 0);
            tick();
        end
        bus.wr_en = 1'b0;
        bus.clear = 1'b0;
        wait_idle(34 * 41 + 100);
        check("rand_all_frames_seen", exp_frames.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
